// File: rtl/log_addr_ctrl.sv
// ---------------------------------------------------------------------------
// log_addr_ctrl
// Write/read address controller for the sample-log RAM.
//   mode 0 : one-shot fill of the whole buffer, addresses 0 .. DEPTH-1.
//   mode 1 : circular capture until a trigger is seen, then a programmable
//            number of post-trigger writes.
// After capture the block sits in FULL and serves read addresses from the
// micro until i_clear returns it to IDLE.
//
// Ports
//   clock             rising-edge system clock
//   i_reset           synchronous active-high reset
//   i_run_log         level, capture enabled
//   i_mode            capture mode, latched on IDLE->ARMED
//   i_trigger         trigger qualifier (ARMED, mode 1)
//   i_post_len        writes after the trigger write, latched on trigger
//   i_read_log        in FULL: load o_addr from i_addr_log_to_mem
//   i_addr_log_to_mem read address from the micro
//   i_clear           return to IDLE and drop captured status
//   o_addr            RAM address (write in ARMED/POST, read in FULL)
//   o_wr_en           RAM write strobe
//   o_mem_full        capture finished, buffer readable
//   o_busy            ARMED or POST
//   o_trig_seen       trigger accepted in this capture
//   o_trig_addr       address written in the trigger cycle
//   o_oldest_addr     address of the oldest valid sample
// ---------------------------------------------------------------------------
module log_addr_ctrl #(
    parameter int ADDR_W = 15
) (
    input  logic              clock,
    input  logic              i_reset,
    input  logic              i_run_log,
    input  logic              i_mode,
    input  logic              i_trigger,
    input  logic [ADDR_W-1:0] i_post_len,
    input  logic              i_read_log,
    input  logic [ADDR_W-1:0] i_addr_log_to_mem,
    input  logic              i_clear,
    output logic [ADDR_W-1:0] o_addr,
    output logic              o_wr_en,
    output logic              o_mem_full,
    output logic              o_busy,
    output logic              o_trig_seen,
    output logic [ADDR_W-1:0] o_trig_addr,
    output logic [ADDR_W-1:0] o_oldest_addr
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARMED = 2'd1,
        S_POST  = 2'd2,
        S_FULL  = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0] ADDR_MAX = '1;
    localparam logic [ADDR_W-1:0] CNT_ONE  = ADDR_W'(1);

    state_t            state_reg, state_next;
    logic              mode_reg, mode_next;
    logic              wrapped_reg, wrapped_next;
    logic [ADDR_W-1:0] cnt_reg, cnt_next;
    logic [ADDR_W-1:0] addr_reg, addr_next;
    logic              wr_en_reg, wr_en_next;
    logic              full_reg, full_next;
    logic              busy_reg, busy_next;
    logic              seen_reg, seen_next;
    logic [ADDR_W-1:0] trig_addr_reg, trig_addr_next;
    logic [ADDR_W-1:0] oldest_reg, oldest_next;

    logic [ADDR_W-1:0] addr_inc;
    logic              addr_at_max;
    logic              trig_accept;

    assign addr_inc    = addr_reg + 1'b1;   // natural modulo-DEPTH wrap
    assign addr_at_max = (addr_reg == ADDR_MAX);
    // A trigger only counts while the capture is still running; a cycle that
    // drops i_run_log truncates instead.
    assign trig_accept = (state_reg == S_ARMED) && mode_reg && i_run_log && i_trigger;

    // ---------------- state and output registers ----------------
    always_ff @(posedge clock) begin
        if (i_reset) begin
            state_reg     <= S_IDLE;
            mode_reg      <= 1'b0;
            wrapped_reg   <= 1'b0;
            cnt_reg       <= '0;
            addr_reg      <= '0;
            wr_en_reg     <= 1'b0;
            full_reg      <= 1'b0;
            busy_reg      <= 1'b0;
            seen_reg      <= 1'b0;
            trig_addr_reg <= '0;
            oldest_reg    <= '0;
        end else begin
            state_reg     <= state_next;
            mode_reg      <= mode_next;
            wrapped_reg   <= wrapped_next;
            cnt_reg       <= cnt_next;
            addr_reg      <= addr_next;
            wr_en_reg     <= wr_en_next;
            full_reg      <= full_next;
            busy_reg      <= busy_next;
            seen_reg      <= seen_next;
            trig_addr_reg <= trig_addr_next;
            oldest_reg    <= oldest_next;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE: begin
                if (i_run_log)
                    state_next = S_ARMED;
            end
            S_ARMED: begin
                if (!i_run_log)
                    state_next = S_FULL;
                else if (!mode_reg) begin
                    if (addr_at_max)
                        state_next = S_FULL;
                end else if (i_trigger)
                    state_next = (i_post_len == '0) ? S_FULL : S_POST;
            end
            S_POST: begin
                if (!i_run_log || cnt_reg == CNT_ONE)
                    state_next = S_FULL;
            end
            S_FULL: state_next = S_FULL;
            default: state_next = S_IDLE;
        endcase
        if (i_clear)
            state_next = S_IDLE;
    end

    // ---------------- datapath / output next values ----------------
    always_comb begin
        mode_next      = mode_reg;
        wrapped_next   = wrapped_reg;
        cnt_next       = cnt_reg;
        addr_next      = addr_reg;
        seen_next      = seen_reg;
        trig_addr_next = trig_addr_reg;
        oldest_next    = oldest_reg;

        case (state_reg)
            S_IDLE: begin
                addr_next = '0;
                if (state_next == S_ARMED) begin
                    mode_next      = i_mode;
                    wrapped_next   = 1'b0;
                    seen_next      = 1'b0;
                    trig_addr_next = '0;
                    oldest_next    = '0;
                end
            end
            S_ARMED, S_POST: begin
                addr_next = addr_inc;
                // Only circular captures can have overwritten old samples.
                if (mode_reg && addr_at_max)
                    wrapped_next = 1'b1;
                if (trig_accept) begin
                    trig_addr_next = addr_reg;
                    seen_next      = 1'b1;
                    cnt_next       = i_post_len;
                end
                if (state_reg == S_POST)
                    cnt_next = cnt_reg - 1'b1;
            end
            S_FULL: begin
                if (i_read_log)
                    addr_next = i_addr_log_to_mem;
            end
            default: ;
        endcase

        // On entering FULL the next write address is where the oldest
        // surviving sample sits once the buffer has wrapped.
        if (state_next == S_FULL && state_reg != S_FULL)
            oldest_next = wrapped_next ? addr_next : '0;

        if (i_clear) begin
            addr_next      = '0;
            wrapped_next   = 1'b0;
            seen_next      = 1'b0;
            trig_addr_next = '0;
            oldest_next    = '0;
        end

        wr_en_next = (state_next == S_ARMED) || (state_next == S_POST);
        busy_next  = wr_en_next;
        full_next  = (state_next == S_FULL);
    end

    assign o_addr        = addr_reg;
    assign o_wr_en       = wr_en_reg;
    assign o_mem_full    = full_reg;
    assign o_busy        = busy_reg;
    assign o_trig_seen   = seen_reg;
    assign o_trig_addr   = trig_addr_reg;
    assign o_oldest_addr = oldest_reg;

endmodule
